riscv_multicycle_cpu: RTL and testbench
=======================================

Name: riscv_multicycle_cpu

Overview:
- Multi-cycle successor to the team's single-cycle RV32I core.
- Owns its PC, instruction register and register file internally, and talks to one unified memory port through a req/ready handshake, so memory may insert wait states.
- Fixes signed compares, register-based branch conditions and jalr decode.
- Adds reset, halt-on-illegal and retire reporting; sits between the testbench memory model and the debug monitor.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
REG_COUNT, 32, number of architectural registers (32 for RV32I, 16 for RV32E); register indices >= REG_COUNT are illegal.
HALT_ON_ILLEGAL, 1, 1: an illegal instruction enters HALT; 0: it retires as a NOP.

Ports:
clk  input  1  clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
mem_req  output  1  memory request valid.
mem_we  output  1  1 = store, 0 = load/fetch; valid only while mem_req is high.
mem_addr  output  32  byte address, word-aligned.
mem_wdata  output  32  store data.
mem_rdata  input  32  read data, sampled on the edge where mem_req && mem_ready.
mem_ready  input  1  memory completes the request on this edge.
retire  output  1  one-cycle pulse per retired instruction.
retire_pc  output  32  PC of the retiring instruction, valid while retire is high.
halted  output  1  core is in HALT.

Behaviour:
- Reset (async assert): state = FETCH, pc = RESET_PC, x1..x(REG_COUNT-1) = 0, ir = 0.
  - All outputs read 0 at reset: mem_req, mem_we, mem_addr, mem_wdata, retire, retire_pc, halted.
  - Reset mid-transaction aborts it; mem_req falls immediately; no register or PC update.
- FSM states: FETCH, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req = 1, mem_we = 0, mem_addr = pc.
  - Hold until an edge with mem_ready = 1, then ir <= mem_rdata and go to EXEC.
- EXEC (1 cycle):
  - Decode ir; read rs1/rs2 (index 0 reads 0).
  - Compute ALU result / effective address / next PC into internal registers.
  - Go to MEM for lw/sw, to HALT for an illegal instruction with HALT_ON_ILLEGAL = 1, otherwise to WB.
- MEM:
  - mem_req = 1, mem_addr = rs1 + sext(imm); mem_we = 1 and mem_wdata = rs2 for sw.
  - Address, we and wdata stay stable until the mem_ready edge.
  - On that edge, lw captures mem_rdata. Go to WB.
- WB (1 cycle):
  - Write rd when the instruction writes and rd != 0.
  - pc <= next_pc; retire = 1 with retire_pc = old pc. Go to FETCH.
- Cycle counts at zero-wait memory (mem_ready tied 1): 3 cycles per ALU/branch/jump instruction, 4 per lw/sw. Each wait cycle adds 1.
- Supported instructions:
  - add, sub, and, or, slt (signed), sltu.
  - addi, andi, ori, slti (signed) — all with sign-extended imm.
  - lw, sw, lui.
  - beq, bne, blt (signed), bge (signed), bltu, bgeu — compare register values, never indices.
  - jal, jalr: rd <= pc+4; jalr target = (rs1 + sext(imm)) & ~1.
- Immediates are sign-extended to 32 bits; B/J immediates have bit 0 = 0.
- All arithmetic is mod 2^32; PC wraps from 0xFFFFFFFC to 0x00000000 without error.
- Illegal instruction (checked in EXEC) is any of:
  - unknown opcode, funct3 or funct7;
  - rs1/rs2/rd >= REG_COUNT;
  - a branch or jump target with bits [1:0] != 0;
  - a lw/sw effective address with bits [1:0] != 0.
- Illegal with HALT_ON_ILLEGAL = 0: treated as a NOP — no write, no memory access, next_pc = pc + 4, passes through WB and retires.
- HALT: mem_req = 0, halted = 1, no retire; left only via reset.
- mem_ready while mem_req = 0 is ignored.
- Write to x0 is discarded; x0 always reads 0.
- With REG_COUNT = 16 the register array has 16 entries.

Test Plan:
- Reset + ALU, zero-wait: rst_n low then high, program "addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; slt x4,x2,x1; sltu x5,x2,x1" -> x3 = 2, x4 = 1, x5 = 0; retire pulses 3 cycles apart; first fetch at mem_addr = RESET_PC.
- Memory with waits: ready delayed 2 cycles on every request, program "addi x1,x0,0x40; sw x1,4(x1); lw x2,4(x1)":
  - store request has mem_addr = 0x44, mem_wdata = 0x40, with address/wdata stable across the waits;
  - x2 = 0x40;
  - lw takes 4 + 2×2 = 8 cycles.
- Branches: x1 = -1, x2 = 1 -> blt x1,x2 taken, bltu x1,x2 not taken, beq x0,x0,+8 skips one instruction; retire_pc sequence confirms.
- Jumps: jal x1,+12 at pc 0x10 -> x1 = 0x14, next fetch at 0x1C; then jalr x0,1(x1) -> next fetch 0x14 (bit 0 cleared).
- Illegal: opcode 0x7F with HALT_ON_ILLEGAL = 1 -> halted = 1 two cycles after the fetch completes, mem_req stays 0, no retire. With HALT_ON_ILLEGAL = 0 -> retires as a NOP, pc + 4.
- Async reset mid-MEM with mem_ready held 0 -> mem_req drops the same cycle; after release, fetch restarts at RESET_PC and x1..x31 = 0; addi x0,x0,7 leaves x0 = 0.

Source files
------------

// File: rtl/riscv_multicycle_cpu.sv
// Multi-cycle RV32I subset core with a single req/ready memory port.
// State | meaning: FETCH read ir at pc | EXEC decode/compute | MEM lw/sw access | WB write rd, retire | HALT stopped until reset
module riscv_multicycle_cpu #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          REG_COUNT       = 32,
    parameter int          HALT_ON_ILLEGAL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic [31:0] retire_pc,
    output logic        halted
);
    localparam int IW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      state;
    logic [31:0] pc, ir, alu_q, npc_q;
    logic [4:0]  rd_q;
    logic        wen_q;
    logic [31:0] regs [REG_COUNT];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4;
    logic [31:0] result, npc, addr;
    logic        illegal, wen, is_mem, is_store, taken;
    logic        use_rs1, use_rs2, use_rd;

    assign opcode   = ir[6:0];
    assign rd       = ir[11:7];
    assign funct3   = ir[14:12];
    assign rs1      = ir[19:15];
    assign rs2      = ir[24:20];
    assign funct7   = ir[31:25];
    assign imm_i    = {{20{ir[31]}}, ir[31:20]};
    assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u    = {ir[31:12], 12'd0};
    assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign pc_plus4 = pc + 32'd4;

    // Out-of-range indices read 0 so the array is never over-indexed; they are flagged illegal below.
    assign rs1_val = (rs1 == 5'd0 || 32'(rs1) >= REG_COUNT) ? 32'd0 : regs[rs1[IW-1:0]];
    assign rs2_val = (rs2 == 5'd0 || 32'(rs2) >= REG_COUNT) ? 32'd0 : regs[rs2[IW-1:0]];

    always_comb begin
        illegal  = 1'b0;
        wen      = 1'b0;
        is_mem   = 1'b0;
        is_store = 1'b0;
        taken    = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        result   = 32'd0;
        npc      = pc_plus4;
        addr     = rs1_val + imm_i;
        case (opcode)
            OPC_OP: begin
                {use_rs1, use_rs2, use_rd, wen} = 4'b1111;
                if (funct7 == 7'd0) begin
                    case (funct3)
                        3'b000:  result = rs1_val + rs2_val;
                        3'b111:  result = rs1_val & rs2_val;
                        3'b110:  result = rs1_val | rs2_val;
                        3'b010:  result = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
                        3'b011:  result = {31'd0, rs1_val < rs2_val};
                        default: illegal = 1'b1;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    result = rs1_val - rs2_val;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                {use_rs1, use_rd, wen} = 3'b111;
                case (funct3)
                    3'b000:  result = rs1_val + imm_i;
                    3'b111:  result = rs1_val & imm_i;
                    3'b110:  result = rs1_val | imm_i;
                    3'b010:  result = {31'd0, $signed(rs1_val) < $signed(imm_i)};
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                {use_rs1, use_rd, wen, is_mem} = 4'b1111;
                illegal = (funct3 != 3'b010) || (addr[1:0] != 2'b00);
            end
            OPC_STORE: begin
                {use_rs1, use_rs2, is_mem, is_store} = 4'b1111;
                addr    = rs1_val + imm_s;
                illegal = (funct3 != 3'b010) || (addr[1:0] != 2'b00);
            end
            OPC_LUI: begin
                {use_rd, wen} = 2'b11;
                result = imm_u;
            end
            OPC_BRANCH: begin
                {use_rs1, use_rs2} = 2'b11;
                case (funct3)
                    3'b000:  taken = rs1_val == rs2_val;
                    3'b001:  taken = rs1_val != rs2_val;
                    3'b100:  taken = $signed(rs1_val) < $signed(rs2_val);
                    3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
                    3'b110:  taken = rs1_val < rs2_val;
                    3'b111:  taken = rs1_val >= rs2_val;
                    default: illegal = 1'b1;
                endcase
                if (taken) npc = pc + imm_b;
                if (npc[1:0] != 2'b00) illegal = 1'b1;
            end
            OPC_JAL: begin
                {use_rd, wen} = 2'b11;
                result  = pc_plus4;
                npc     = pc + imm_j;
                illegal = npc[1:0] != 2'b00;
            end
            OPC_JALR: begin
                {use_rs1, use_rd, wen} = 3'b111;
                result  = pc_plus4;
                npc     = (rs1_val + imm_i) & ~32'd1;
                illegal = (funct3 != 3'b000) || (npc[1:0] != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
        if ((use_rs1 && 32'(rs1) >= REG_COUNT) || (use_rs2 && 32'(rs2) >= REG_COUNT) ||
            (use_rd && 32'(rd) >= REG_COUNT))
            illegal = 1'b1;
        if (illegal) begin
            wen      = 1'b0;
            is_mem   = 1'b0;
            is_store = 1'b0;
            npc      = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= 32'd0;
            alu_q     <= 32'd0;
            npc_q     <= 32'd0;
            rd_q      <= 5'd0;
            wen_q     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            retire    <= 1'b0;
            retire_pc <= 32'd0;
            halted    <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= 32'd0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    // Only right after reset is mem_req low here; WB normally raises it.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ready) begin
                        ir      <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (illegal && HALT_ON_ILLEGAL != 0) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        alu_q <= result;
                        npc_q <= npc;
                        wen_q <= wen && (rd != 5'd0);
                        rd_q  <= rd;
                        if (is_mem) begin
                            state     <= S_MEM;
                            mem_req   <= 1'b1;
                            mem_addr  <= addr;
                            mem_we    <= is_store;
                            mem_wdata <= is_store ? rs2_val : 32'd0;
                        end else begin
                            state     <= S_WB;
                            retire    <= 1'b1;
                            retire_pc <= pc;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        if (!mem_we) alu_q <= mem_rdata;
                        state     <= S_WB;
                        retire    <= 1'b1;
                        retire_pc <= pc;
                    end
                end
                S_WB: begin
                    if (wen_q) regs[rd_q[IW-1:0]] <= alu_q;
                    pc       <= npc_q;
                    state    <= S_FETCH;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= npc_q;
                end
                S_HALT: ;
                default: state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_multicycle_cpu.sv
// Directed bench for riscv_multicycle_cpu: small ROM/RAM model with programmable wait states.
module tb_riscv_multicycle_cpu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst2_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, retire_pc;
    logic        nop_req, nop_we, nop_retire, nop_halted;
    logic [31:0] nop_addr, nop_wdata, nop_rdata, nop_retire_pc;

    logic [31:0] rom [16];
    logic [31:0] ram [64];
    int          wait_n = 0, cnt = 0, cyc = 0, ret_cnt = 0, nop_cnt = 0;
    bit          hold_low = 1'b0;
    logic [31:0] ret_pc [256];
    int          ret_cyc [256];
    logic [31:0] nop_pc [256];
    int          checks = 0, failures = 0;
    int          base, n;
    logic [31:0] acc, seen;
    logic [31:0] exp3 [7];
    logic [31:0] exp4 [8];

    localparam logic [31:0] JSPIN = 32'h0000_006F;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    always #5 clk = ~clk;

    riscv_multicycle_cpu #(.RESET_PC(32'h0), .REG_COUNT(32), .HALT_ON_ILLEGAL(1)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .retire(retire), .retire_pc(retire_pc), .halted(halted));

    riscv_multicycle_cpu #(.RESET_PC(32'h0), .REG_COUNT(32), .HALT_ON_ILLEGAL(0)) dut_nop (
        .clk(clk), .rst_n(rst2_n), .mem_req(nop_req), .mem_we(nop_we), .mem_addr(nop_addr),
        .mem_wdata(nop_wdata), .mem_rdata(nop_rdata), .mem_ready(1'b1),
        .retire(nop_retire), .retire_pc(nop_retire_pc), .halted(nop_halted));

    assign mem_ready = !(hold_low && mem_addr >= 32'h40) && (cnt >= wait_n);
    assign mem_rdata = (mem_addr < 32'h40) ? rom[mem_addr[5:2]] : ram[mem_addr[7:2]];
    assign nop_rdata = rom[nop_addr[5:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req && mem_ready) begin
            cnt <= 0;
            if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
        end else if (mem_req) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
        if (retire) begin
            ret_pc[ret_cnt % 256]  <= retire_pc;
            ret_cyc[ret_cnt % 256] <= cyc;
            ret_cnt <= ret_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (nop_retire) begin
            nop_pc[nop_cnt % 256] <= nop_retire_pc;
            nop_cnt <= nop_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] op_i(input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] op_r(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_br(input logic [2:0] f3, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [12:0] off);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    task automatic load_nops();
        for (int i = 0; i < 16; i++) rom[i] = NOP;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        hold_low = 1'b0;
        wait_n   = 0;
        @(negedge clk);
        check_val("rst_ctrl", {28'd0, mem_req, mem_we, retire, halted}, 32'd0);
        check_val("rst_addr", mem_addr, 32'd0);
        check_val("rst_wdata", mem_wdata, 32'd0);
        check_val("rst_retire_pc", retire_pc, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int k = 0;
        @(negedge clk);
        while (!mem_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        check_val(tag, mem_addr, exp_addr);
    endtask

    task automatic wait_retires(input int target, input int budget);
        int k = 0;
        while (ret_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (ret_cnt < target) check_val("retire_timeout", ret_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'd0;

        // ALU program, zero-wait
        load_nops();
        rom[0] = op_i(3'b000, 5'd1, 5'd0, 12'd5);
        rom[1] = op_i(3'b000, 5'd2, 5'd0, 12'hFFD);
        rom[2] = op_r(7'd0, 3'b000, 5'd3, 5'd1, 5'd2);
        rom[3] = op_r(7'd0, 3'b010, 5'd4, 5'd2, 5'd1);
        rom[4] = op_r(7'd0, 3'b011, 5'd5, 5'd2, 5'd1);
        rom[5] = JSPIN;
        apply_reset();
        base = ret_cnt;
        wait_req("t1_first_fetch", 32'h0);
        wait_retires(base + 5, 100);
        check_val("t1_x1", dut.regs[1], 32'd5);
        check_val("t1_x2", dut.regs[2], 32'hFFFF_FFFD);
        check_val("t1_x3", dut.regs[3], 32'd2);
        check_val("t1_x4_slt", dut.regs[4], 32'd1);
        check_val("t1_x5_sltu", dut.regs[5], 32'd0);
        for (int i = 0; i < 5; i++) check_val("t1_retire_pc", ret_pc[(base + i) % 256], 32'(4 * i));
        for (int i = 1; i < 5; i++)
            check_val("t1_retire_gap", ret_cyc[(base + i) % 256] - ret_cyc[(base + i - 1) % 256], 32'd3);

        // Store/load with two wait cycles per request
        load_nops();
        rom[0] = op_i(3'b000, 5'd1, 5'd0, 12'h040);
        rom[1] = enc_sw(5'd1, 5'd1, 12'd4);
        rom[2] = enc_lw(5'd2, 5'd1, 12'd4);
        rom[3] = JSPIN;
        apply_reset();
        wait_n = 2;
        base = ret_cnt;
        n = 0;
        @(negedge clk);
        while (!(mem_req && mem_we) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("t2_st_we", {31'd0, mem_we}, 32'd1);
        check_val("t2_st_addr", mem_addr, 32'h44);
        check_val("t2_st_wdata", mem_wdata, 32'h40);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("t2_hold_req", {30'd0, mem_req, mem_we}, 32'd3);
            check_val("t2_hold_addr", mem_addr, 32'h44);
            check_val("t2_hold_wdata", mem_wdata, 32'h40);
        end
        wait_retires(base + 3, 200);
        check_val("t2_ram", ram[17], 32'h40);
        check_val("t2_x2", dut.regs[2], 32'h40);
        check_val("t2_lw_cycles", ret_cyc[(base + 2) % 256] - ret_cyc[(base + 1) % 256], 32'd8);
        wait_n = 0;

        // Branches on register values
        load_nops();
        rom[0] = op_i(3'b000, 5'd1, 5'd0, 12'hFFF);
        rom[1] = op_i(3'b000, 5'd2, 5'd0, 12'd1);
        rom[2] = enc_br(3'b100, 5'd1, 5'd2, 13'd8);
        rom[3] = op_i(3'b000, 5'd3, 5'd0, 12'd1);
        rom[4] = enc_br(3'b110, 5'd1, 5'd2, 13'd8);
        rom[5] = enc_br(3'b000, 5'd0, 5'd0, 13'd8);
        rom[6] = op_i(3'b000, 5'd3, 5'd0, 12'd2);
        rom[7] = op_i(3'b000, 5'd4, 5'd0, 12'd9);
        rom[8] = JSPIN;
        exp3 = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h1C, 32'h20};
        apply_reset();
        base = ret_cnt;
        wait_retires(base + 7, 100);
        for (int i = 0; i < 7; i++) check_val("t3_retire_pc", ret_pc[(base + i) % 256], exp3[i]);
        check_val("t3_x3_skipped", dut.regs[3], 32'd0);
        check_val("t3_x4", dut.regs[4], 32'd9);

        // jal / jalr
        load_nops();
        rom[4] = enc_jal(5'd1, 21'd12);
        rom[5] = op_i(3'b000, 5'd5, 5'd0, 12'd3);
        rom[6] = JSPIN;
        rom[7] = enc_jalr(5'd0, 5'd1, 12'd1);
        exp4 = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h14, 32'h18};
        apply_reset();
        base = ret_cnt;
        wait_retires(base + 8, 100);
        for (int i = 0; i < 8; i++) check_val("t4_retire_pc", ret_pc[(base + i) % 256], exp4[i]);
        check_val("t4_x1_link", dut.regs[1], 32'h14);
        check_val("t4_x5", dut.regs[5], 32'd3);

        // Illegal opcode: halting core, then the NOP-retiring core
        load_nops();
        rom[0] = op_i(3'b000, 5'd1, 5'd0, 12'd1);
        rom[1] = 32'h0000_007F;
        rom[2] = JSPIN;
        apply_reset();
        base = ret_cnt;
        wait_retires(base + 1, 50);
        check_val("t5_fetch_illegal", mem_addr, 32'h04);
        @(negedge clk);
        check_val("t5_exec_not_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        check_val("t5_halted", {31'd0, halted}, 32'd1);
        seen = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | {30'd0, retire, mem_req};
        end
        check_val("t5_quiet_after_halt", seen, 32'd0);
        check_val("t5_retire_count", ret_cnt, base + 1);
        check_val("t5_still_halted", {31'd0, halted}, 32'd1);
        rst2_n = 1'b1;
        n = 0;
        while (nop_cnt < 3 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_val("t5n_retire_count", nop_cnt, 32'd3);
        for (int i = 0; i < 3; i++) check_val("t5n_retire_pc", nop_pc[i], 32'(4 * i));
        check_val("t5n_not_halted", {29'd0, nop_halted, nop_we, 1'b0}, 32'd0);
        check_val("t5n_x1", dut_nop.regs[1], 32'd1);
        check_val("t5n_wdata", nop_wdata, 32'd0);

        // Async reset while a load waits on memory
        load_nops();
        rom[0] = op_i(3'b000, 5'd1, 5'd0, 12'h040);
        rom[1] = enc_lw(5'd2, 5'd1, 12'd0);
        rom[2] = JSPIN;
        apply_reset();
        hold_low = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(mem_req && mem_addr == 32'h40) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("t6_mem_stall_addr", mem_addr, 32'h40);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_abort_req", {31'd0, mem_req}, 32'd0);
        acc = 32'd0;
        for (int i = 1; i < 32; i++) acc = acc | dut.regs[i];
        check_val("t6_regs_cleared", acc, 32'd0);
        load_nops();
        rom[0] = op_i(3'b000, 5'd0, 5'd0, 12'd7);
        rom[1] = op_i(3'b000, 5'd6, 5'd0, 12'd3);
        rom[2] = op_r(7'd0, 3'b000, 5'd7, 5'd0, 5'd6);
        rom[3] = JSPIN;
        hold_low = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = ret_cnt;
        wait_req("t6_restart_fetch", 32'h0);
        wait_retires(base + 3, 60);
        check_val("t6_x0", dut.regs[0], 32'd0);
        check_val("t6_x7", dut.regs[7], 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
